// File: rtl/maze_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : maze_pkg
//  Brief    : Shared maze constants and collision-detector state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package maze_pkg;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int NUM_WALLS = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } coll_state_t;

endpackage
`default_nettype wire

// File: rtl/maze_player_box_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : maze_player_box_cmp
//  Brief    : Player box hit test with per-frame position latch.
//  Revision : 1.0 - initial release
// ============================================================================
module maze_player_box_cmp
  import maze_pkg::*;
#(
  parameter int PLAYER_SIZE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [9:0] xCount,
  input  logic [9:0] yCount,
  input  logic [9:0] playerX,
  input  logic [9:0] playerY,
  output logic       in_box
);

  logic [9:0]  r_px;
  logic [9:0]  r_py;
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [10:0] w_px;
  logic [10:0] w_py;
  logic [10:0] w_px_end;
  logic [10:0] w_py_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_px <= 10'd0;
      r_py <= 10'd0;
    end else if (load) begin
      r_px <= playerX;
      r_py <= playerY;
    end
  end

  // 11-bit arithmetic keeps the far edge from wrapping near 1023
  assign w_x      = {1'b0, xCount};
  assign w_y      = {1'b0, yCount};
  assign w_px     = {1'b0, r_px};
  assign w_py     = {1'b0, r_py};
  assign w_px_end = w_px + 11'(PLAYER_SIZE);
  assign w_py_end = w_py + 11'(PLAYER_SIZE);

  assign in_box = (w_x > w_px) && (w_x < w_px_end) &&
                  (w_y > w_py) && (w_y < w_py_end);

endmodule
`default_nettype wire

// File: rtl/maze_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module   : maze_collision_detector
//  Brief    : Per-frame player/wall overlap detector with valid/ack result.
//  Revision : 1.0 - initial release
// ============================================================================
module maze_collision_detector
  import maze_pkg::*;
#(
  parameter int PLAYER_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [9:0]           xCount,
  input  logic [9:0]           yCount,
  input  logic [NUM_WALLS-1:0] wall,
  input  logic [9:0]           playerX,
  input  logic [9:0]           playerY,
  input  logic                 result_ack,
  output logic                 result_valid,
  output logic                 collision,
  output logic [NUM_WALLS-1:0] wall_mask,
  output logic [7:0]           hit_count,
  output logic                 overrun
);

  logic                 w_sof;
  logic                 w_eof;
  logic                 w_active;
  logic                 w_in_box;
  logic                 r_pib_d1;
  logic                 r_sof_d1;
  logic                 r_eof_d1;
  logic [NUM_WALLS-1:0] w_hit;
  coll_state_t          r_state;

  assign w_sof    = (xCount == 10'd0) && (yCount == 10'd0);
  assign w_eof    = (xCount == 10'(H_ACTIVE - 1)) && (yCount == 10'(V_ACTIVE - 1));
  assign w_active = (xCount < 10'(H_ACTIVE)) && (yCount < 10'(V_ACTIVE));

  maze_player_box_cmp #(
    .PLAYER_SIZE (PLAYER_SIZE)
  ) u_box (
    .clk     (clk),
    .rst     (rst),
    .load    (w_sof),
    .xCount  (xCount),
    .yCount  (yCount),
    .playerX (playerX),
    .playerY (playerY),
    .in_box  (w_in_box)
  );

  // Stage 0: align the box test with the wall generator's registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pib_d1 <= 1'b0;
      r_sof_d1 <= 1'b0;
      r_eof_d1 <= 1'b0;
    end else begin
      r_pib_d1 <= w_in_box & w_active;
      r_sof_d1 <= w_sof;
      r_eof_d1 <= w_eof;
    end
  end

  assign w_hit = wall & {NUM_WALLS{r_pib_d1}};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      wall_mask    <= '0;
      hit_count    <= 8'd0;
      collision    <= 1'b0;
      result_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_sof_d1) begin
            r_state   <= SCAN;
            wall_mask <= '0;
            hit_count <= 8'd0;
            collision <= 1'b0;
          end
        end
        SCAN: begin
          wall_mask <= wall_mask | w_hit;
          collision <= |(wall_mask | w_hit);
          if ((|w_hit) && (hit_count != 8'hFF)) begin
            hit_count <= hit_count + 8'd1;
          end
          if (r_eof_d1) begin
            r_state      <= HOLD;
            result_valid <= 1'b1;
          end
        end
        HOLD: begin
          if (result_ack) begin
            result_valid <= 1'b0;
            overrun      <= 1'b0;
            // An ack landing on frame start rolls straight into the new scan
            if (r_sof_d1) begin
              r_state   <= SCAN;
              wall_mask <= '0;
              hit_count <= 8'd0;
              collision <= 1'b0;
            end else begin
              r_state <= IDLE;
            end
          end else if (r_sof_d1) begin
            overrun <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maze_collision_detector.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maze_collision_detector
//  Brief    : Directed frame-level bench for maze_collision_detector.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maze_collision_detector;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  xCount, yCount, playerX, playerY;
  logic [17:0] wall;
  logic        result_ack;

  logic        v16, c16, o16, v32, c32, o32;
  logic [17:0] m16, m32;
  logic [7:0]  n16, n32;

  int n_tests = 0;
  int n_fail  = 0;
  int wmode   = 0;
  int prev_x  = 1000;
  int prev_y  = 1000;

  always #5 clk = ~clk;

  maze_collision_detector #(.PLAYER_SIZE(16)) u_dut16 (
    .clk(clk), .rst(rst), .xCount(xCount), .yCount(yCount), .wall(wall),
    .playerX(playerX), .playerY(playerY), .result_ack(result_ack),
    .result_valid(v16), .collision(c16), .wall_mask(m16), .hit_count(n16),
    .overrun(o16)
  );

  maze_collision_detector #(.PLAYER_SIZE(32)) u_dut32 (
    .clk(clk), .rst(rst), .xCount(xCount), .yCount(yCount), .wall(wall),
    .playerX(playerX), .playerY(playerY), .result_ack(result_ack),
    .result_valid(v32), .collision(c32), .wall_mask(m32), .hit_count(n32),
    .overrun(o32)
  );

  typedef struct {
    int          px;
    int          py;
    int          mode;
    logic [17:0] m16;
    int          c16;
    logic [17:0] m32;
    int          c32;
  } vec_t;

  vec_t vecs[5];

  // Upstream wall generator model: mode 1 places a block plus a ring around box edges
  function automatic logic [17:0] gen(input int m, input int x, input int y);
    logic [17:0] g;
    g = '0;
    if (m == 2) begin
      g = 18'h3FFFF;
    end else if (m == 1) begin
      if (x >= 201 && x <= 210 && y >= 101 && y <= 105) g[3] = 1'b1;
      if ((x == 200 || x == 216) && y >= 100 && y <= 116) g[7] = 1'b1;
      if ((y == 100 || y == 116) && x >= 200 && x <= 216) g[9] = 1'b1;
    end
    return g;
  endfunction

  task automatic pix(input int x, input int y);
    wall   = gen(wmode, prev_x, prev_y);
    xCount = 10'(x);
    yCount = 10'(y);
    prev_x = x;
    prev_y = y;
    @(negedge clk);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk16(input string tag, input int v, input int m, input int c, input int o);
    check({tag, " valid16"}, int'(v16), v);
    check({tag, " mask16"}, int'(m16), m);
    check({tag, " count16"}, int'(n16), c);
    check({tag, " coll16"}, int'(c16), (m != 0) ? 1 : 0);
    check({tag, " ovr16"}, int'(o16), o);
  endtask

  task automatic chk32(input string tag, input int v, input int m, input int c, input int o);
    check({tag, " valid32"}, int'(v32), v);
    check({tag, " mask32"}, int'(m32), m);
    check({tag, " count32"}, int'(n32), c);
    check({tag, " coll32"}, int'(c32), (m != 0) ? 1 : 0);
    check({tag, " ovr32"}, int'(o32), o);
  endtask

  task automatic ack_pulse();
    result_ack = 1'b1;
    pix(1000, 1000);
    result_ack = 1'b0;
  endtask

  // Frame: sof pixel, one blank, sweep around the box, last active pixel
  task automatic run_frame(input int px, input int py, input int mode,
                           input bit ack_sof, input bit ack_mid);
    playerX = 10'(px);
    playerY = 10'(py);
    wmode   = mode;
    pix(0, 0);
    result_ack = ack_sof;
    pix(1000, 1000);
    result_ack = 1'b0;
    playerX = 10'd600;
    playerY = 10'd10;
    for (int y = py - 4; y <= py + 36; y++) begin
      for (int x = px - 4; x <= px + 36; x++) begin
        result_ack = ack_mid && (x == px - 4) && (y == py - 4);
        pix(x, y);
        result_ack = 1'b0;
      end
    end
    pix(639, 479);
  endtask

  initial begin
    vecs[0] = '{px:500, py:400, mode:0, m16:18'h00000, c16:0,   m32:18'h00000, c32:0};
    vecs[1] = '{px:200, py:100, mode:1, m16:18'h00008, c16:50,  m32:18'h00288, c32:81};
    vecs[2] = '{px:195, py:95,  mode:1, m16:18'h00288, c16:71,  m32:18'h00288, c32:114};
    vecs[3] = '{px:201, py:101, mode:1, m16:18'h00288, c16:65,  m32:18'h00288, c32:65};
    vecs[4] = '{px:100, py:100, mode:2, m16:18'h3FFFF, c16:225, m32:18'h3FFFF, c32:255};

    rst = 1'b1; result_ack = 1'b0; playerX = 10'd0; playerY = 10'd0;
    xCount = 10'd1000; yCount = 10'd1000; wall = '0;
    @(negedge clk);
    chk16("reset", 0, 0, 0, 0);
    chk32("reset", 0, 0, 0, 0);
    pix(1000, 1000);
    rst = 1'b0;
    pix(1000, 1000);

    for (int i = 0; i < 5; i++) begin
      run_frame(vecs[i].px, vecs[i].py, vecs[i].mode, 1'b0, 1'b1);
      check($sformatf("vec%0d early valid", i), int'(v16), 0);
      pix(1000, 1000);
      chk16($sformatf("vec%0d", i), 1, int'(vecs[i].m16), vecs[i].c16, 0);
      chk32($sformatf("vec%0d", i), 1, int'(vecs[i].m32), vecs[i].c32, 0);
      ack_pulse();
      check($sformatf("vec%0d ack valid", i), int'(v16), 0);
    end

    // Unacknowledged result across a frame start
    run_frame(200, 100, 1, 1'b0, 1'b1);
    pix(1000, 1000);
    chk16("pre-overrun", 1, 'h8, 50, 0);
    run_frame(100, 100, 2, 1'b0, 1'b0);
    pix(1000, 1000);
    chk16("overrun", 1, 'h8, 50, 1);
    chk32("overrun", 1, 'h288, 81, 1);
    ack_pulse();
    check("overrun ack valid", int'(v16), 0);
    check("overrun ack ovr", int'(o16), 0);
    run_frame(500, 400, 0, 1'b0, 1'b1);
    pix(1000, 1000);
    chk16("fresh", 1, 0, 0, 0);

    // Ack in the same cycle as the delayed frame-start marker
    run_frame(200, 100, 1, 1'b1, 1'b0);
    pix(1000, 1000);
    chk16("ack+sof", 1, 'h8, 50, 0);
    chk32("ack+sof", 1, 'h288, 81, 0);

    // Reset in the middle of a (skipped) frame
    playerX = 10'd200; playerY = 10'd100; wmode = 1;
    pix(0, 0);
    pix(1000, 1000);
    check("ovr before rst", int'(o16), 1);
    for (int x = 201; x <= 210; x++) pix(x, 101);
    rst = 1'b1;
    pix(1000, 1000);
    chk16("rst mid", 0, 0, 0, 0);
    pix(1000, 1000);
    pix(1000, 1000);
    rst = 1'b0;
    for (int y = 102; y <= 105; y++)
      for (int x = 201; x <= 210; x++) pix(x, y);
    pix(639, 479);
    pix(1000, 1000);
    pix(1000, 1000);
    check("partial frame valid", int'(v16), 0);
    run_frame(200, 100, 1, 1'b0, 1'b0);
    check("post-rst early valid", int'(v16), 0);
    pix(1000, 1000);
    chk16("post-rst", 1, 'h8, 50, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/maze_collision_detector.md
# maze_collision_detector

Reads the per-pixel `wall[17:0]` hit vector produced by the level wall generator during the raster scan and determines, once per frame, whether the player sprite overlaps any wall. It aligns its own player-box test to the wall generator's one-cycle registered output and accumulates a per-wall hit mask plus an overlap pixel count. It presents the result to the game controller through a valid/ack handshake. It sits between the wall generator/VGA timing and the game-state FSM.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `V_ACTIVE`, 480, active lines per frame
- `NUM_WALLS`, 18, width of the wall vector
- `PLAYER_SIZE`, 16, player box edge length in pixels
- `clk`  in  1  pixel clock, same clock as the wall generator
- `rst`  in  1  reset, synchronous, active-high
- `xCount`  in  10  current pixel column
- `yCount`  in  10  current pixel row
- `wall`  in  NUM_WALLS  wall hit bits; registered upstream, so they describe the pixel presented one cycle earlier
- `playerX`  in  10  player box origin X; sampled at frame start
- `playerY`  in  10  player box origin Y; sampled at frame start
- `result_ack`  in  1  controller consumes the result
- `result_valid`  out  1  frame result available
- `collision`  out  1  OR of `wall_mask`
- `wall_mask`  out  NUM_WALLS  walls overlapped during the frame
- `hit_count`  out  8  overlapping pixels, saturating at 255
- `overrun`  out  1  sticky; set when a frame was skipped while a result was unacknowledged

## Operation
- **Player box test:** `in_box = (x > pX) && (x < pX+PLAYER_SIZE) && (y > pY) && (y < pY+PLAYER_SIZE)`.
  - Strict inequalities, matching the wall generator's convention.
  - Sums are computed in 11 bits, so there is no wrap near 1023.
- **Pipeline stage 0:** register `in_box` to `pib_d1`. Register the frame markers `sof_d1` (pixel 0,0) and `eof_d1` (pixel H_ACTIVE-1, V_ACTIVE-1).
- **Pipeline stage 1:** `hit = wall & {NUM_WALLS{pib_d1}}`.
- **State machine:**
  - IDLE: on the cycle `sof_d1` is high, go to SCAN. Clear the mask and count, and latch `playerX`/`playerY` for the frame.
  - SCAN: each cycle, `mask |= hit`. If `|hit`, `count = min(count+1, 255)`. When `eof_d1` is high, include that pixel, then go to HOLD.
  - HOLD: `result_valid=1`; outputs stay frozen. On `result_ack`, go to IDLE.
- **Frame start in HOLD without ack:** the frame is skipped, `overrun` is set, and the result is unchanged.
- **`sof_d1` and `result_ack` in the same HOLD cycle:** go directly to SCAN and clear the accumulators. This frame is not counted as an overrun.
- **`result_ack` outside HOLD:** ignored.
- **Clearing `overrun`:** on ack, or on `rst`.
- **Player position mid-frame:** changes to `playerX`/`playerY` take effect at the next frame start.

## Timing
- **Reset:** all outputs are 0 and the state is IDLE, on the first edge with `rst`=1.
- **Reset mid-operation:** discards any partial frame. No result is produced until a full frame completes.
- **Latency:** the last active pixel is presented at cycle t; its wall bits arrive at t+1; `result_valid` rises at t+2.
- **Output stability:** `result_valid` is held level until an ack edge. `wall_mask`, `collision` and `hit_count` are stable for the whole HOLD period.
- **Frame detection:** the first frame after reset is the first (0,0) pixel seen while in IDLE.
- **Blanking:** pixels are counted only while the pipeline markers indicate the active region; blanking pixels are ignored.

## Structure
- **Shared package `maze_pkg`:**
  - `H_ACTIVE`, `V_ACTIVE`, `NUM_WALLS`
  - state enum `coll_state_t` {IDLE, SCAN, HOLD}
  - used by the wall generators, the renderer and the game FSM
- **Sub-module `maze_player_box_cmp`:** the stage-0 comparator plus the position latch. It is reusable by the renderer for drawing the sprite.

## Test plan
- **Reset:** assert `rst` for 3 cycles mid-frame -> all outputs 0, state IDLE; first `result_valid` appears 2 cycles after the next complete frame's pixel (639,479).
- **Clear frame:** player at (500,400), `wall`=0 all frame -> `result_valid`=1, `collision`=0, `wall_mask`=0, `hit_count`=0.
- **Partial overlap:**
  - Stimulus: bench drives `wall[3]`=1 (registered) for x 201..210, y 101..105; player at (200,100), size 16.
  - Response: `wall_mask`=18'h00008, `collision`=1, `hit_count`=50.
- **Overrun:** hold `result_ack`=0 across the next (0,0) -> `overrun`=1, mask and count unchanged. Ack -> `result_valid`=0, `overrun`=0, and the following frame reports fresh.
- **Ack coinciding with frame start:** `result_ack` is asserted in the same cycle `sof_d1` is high -> no overrun, and that frame is scanned and reported.
- **Saturation:**
  - Stimulus: `PLAYER_SIZE`=32, `wall`=all ones for the whole frame, player at (100,100).
  - Response: `hit_count`=255 (961 pixels overlap), `wall_mask`=18'h3FFFF.
